// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle HI/LO controller for the decode/execute path. It accepts
// MULT/MULTU/DIV/DIVU requests and runs a STEPS-long shift-add multiply or
// restoring divide on operand magnitudes. A final FIX cycle applies the
// result signs and writes HI/LO once. While busy, the unit stalls decode when
// decode presents a new mul/div or an MFHI/MFLO.
//
// Ports
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   one-cycle mul/div request from decode
//   op       in   2   0=DIVU 1=DIV 2=MULTU 3=MULT, sampled with start
//   a        in   32  rs operand (dividend / multiplicand)
//   b        in   32  rt operand (divisor / multiplier)
//   hilo_rd  in   1   decode holds MFHI/MFLO this cycle
//   busy     out  1   sequence in progress (registered)
//   stall    out  1   busy & (start | hilo_rd), combinational
//   done     out  1   one-cycle pulse after hi/lo are written (registered)
//   hi       out  32  HI: remainder / product upper word
//   lo       out  32  LO: quotient / product lower word
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        hilo_rd,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] count_q;
  logic          is_mul_q;    // 1: multiply, 0: divide
  logic          neg_res_q;   // negate product / quotient in FIX
  logic          neg_rem_q;   // negate remainder (sign of dividend)
  logic          div_zero_q;  // divisor was zero
  logic [31:0]   opnd_q;      // multiplicand or divisor magnitude
  logic [63:0]   acc_q;       // mul: {partial hi, multiplier}; div: {rem, quot}

  // Operand magnitudes; op[0] marks the signed variants.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_neg = op[0] & a[31];
    b_neg = op[0] & b[31];
    a_mag = a_neg ? (32'd0 - a) : a;
    b_mag = b_neg ? (32'd0 - b) : b;
  end

  // One multiply step: conditional add of the multiplicand into the upper
  // word, then shift the whole accumulator right with the carry.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;

  // One restoring-divide step: bring the next dividend bit into the
  // remainder, subtract the divisor when it fits and record a quotient bit.
  // The remainder is always below the divisor, so the 33-bit trial value
  // minus the divisor fits back into 32 bits.
  logic [32:0] div_shift;
  logic        div_ok;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next  = {mul_sum, acc_q[31:1]};
    div_shift = {acc_q[63:32], acc_q[31]};
    div_ok    = (div_shift >= {1'b0, opnd_q});
    div_next  = {div_ok ? (div_shift[31:0] - opnd_q) : div_shift[31:0],
                 acc_q[30:0], div_ok};
  end

  // Sign-corrected results for the FIX edge.
  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix;

  always_comb begin
    prod_fix = neg_res_q ? (64'd0 - acc_q) : acc_q;
    // With a zero divisor the restoring loop leaves rem=|a|; putting back the
    // dividend's sign gives the raw a, and the quotient is forced all ones.
    quot_fix = div_zero_q ? 32'hFFFF_FFFF
             : (neg_res_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0]);
    rem_fix  = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_CALC;
      S_CALC: if (count_q == CW'(STEPS - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign stall = busy & (start | hilo_rd);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: working registers are reset too, so an aborted operation leaves
      // no stale partial result behind.
      state_q    <= S_IDLE;
      count_q    <= '0;
      is_mul_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      hi         <= '0;
      lo         <= '0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != S_IDLE);
      done    <= (state_q == S_FIX);

      unique case (state_q)
        S_IDLE: begin
          // op/a/b are only looked at under start, so X on them while idle
          // never reaches state.
          if (start) begin
            count_q    <= '0;
            is_mul_q   <= op[1];
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg & ~op[1];
            div_zero_q <= ~op[1] & (b == 32'd0);
            opnd_q     <= op[1] ? a_mag : b_mag;
            acc_q      <= {32'd0, op[1] ? b_mag : a_mag};
          end
        end
        S_CALC: begin
          count_q <= count_q + 1'b1;
          acc_q   <= is_mul_q ? mul_next : div_next;
        end
        S_FIX: begin
          if (is_mul_q) begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end else begin
            hi <= rem_fix;
            lo <= quot_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        hilo_rd;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

  logic [63:0] sb[$];  // expected {hi, lo}

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .busy(busy), .stall(stall), .done(done),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model built from the language's own arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [31:0] sx, sy;
    logic signed [63:0] sp;
    sx = x;
    sy = y;
    case (o)
      2'd0: model = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      2'd1: begin
        if (y == 0)                                  model = {x, 32'hFFFF_FFFF};
        else if (x == 32'h8000_0000 && y == '1)      model = {32'd0, 32'h8000_0000};
        else                                         model = {32'(sx % sy), 32'(sx / sy)};
      end
      2'd2: model = {32'd0, x} * {32'd0, y};
      default: begin
        sp = 64'(sx) * 64'(sy);
        model = sp;
      end
    endcase
  endfunction

  // Present a request at the current negedge; returns just after edge N.
  task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit expect_result);
    start = 1'b1; op = o; a = x; b = y;
    #1 check("stall_idle", {63'd0, stall}, 64'd0);
    if (expect_result) sb.push_back(model(o, x, y));
    @(negedge clk);
    start = 1'b0; op = 'x; a = 'x; b = 'x;
    check("busy_after_start", {63'd0, busy}, 64'd1);
  endtask

  // Wait for done; pre = edges already elapsed since edge N.
  task automatic wait_result(input string tag, input int pre);
    int n;
    bit dropped;
    logic [63:0] exp;
    n = pre;
    dropped = 1'b0;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) dropped = 1'b1;
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_held"}, {63'd0, dropped}, 64'd0);
    check({tag, "_busy_clear"}, {63'd0, busy}, 64'd0);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      exp = sb.pop_front();
      check({tag, "_hilo"}, {hi, lo}, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; hilo_rd = 1'b0; op = 'x; a = 'x; b = 'x;
    repeat (2) @(negedge clk);
    check("reset_outputs", {28'd0, busy, stall, done, 1'b0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed cases
    launch(2'd2, 32'hFFFF_FFFF, 32'd2, 1'b1);
    wait_result("multu_max", 0);
    check("multu_const", {hi, lo}, {32'd1, 32'hFFFF_FFFE});
    @(negedge clk);
    check("done_one_cycle", {63'd0, done}, 64'd0);

    launch(2'd3, -32'sd3, 32'd7, 1'b1);
    wait_result("mult_neg", 0);
    check("mult_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});

    launch(2'd1, -32'sd7, 32'd2, 1'b1);
    wait_result("div_neg", 0);
    check("div_const", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    launch(2'd0, 32'd100, 32'd7, 1'b1);
    wait_result("divu", 0);
    check("divu_const", {hi, lo}, {32'd2, 32'd14});

    launch(2'd0, 32'd5, 32'd0, 1'b1);
    wait_result("divu_zero", 0);
    check("divu_zero_const", {hi, lo}, {32'd5, 32'hFFFF_FFFF});

    launch(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_result("div_ovf", 0);
    check("div_ovf_const", {hi, lo}, {32'd0, 32'h8000_0000});

    launch(2'd1, -32'sd9, 32'd0, 1'b1);
    wait_result("div_zero_signed", 0);
    launch(2'd3, 32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_result("mult_min", 0);

    for (int i = 0; i < 8; i++) begin
      launch(2'(i), $urandom, (i == 1) ? 32'($urandom_range(1, 1000)) : $urandom, 1'b1);
      wait_result("random", 0);
    end

    // Stall: second start and hilo_rd while busy
    launch(2'd0, 32'd1000, 32'd3, 1'b1);
    repeat (4) @(negedge clk);
    start = 1'b1; hilo_rd = 1'b1; op = 2'd2; a = 32'd9; b = 32'd9;
    #1 check("stall_busy", {63'd0, stall}, 64'd1);
    @(negedge clk);
    start = 1'b0; hilo_rd = 1'b0; op = 'x; a = 'x; b = 'x;
    check("busy_after_drop", {63'd0, busy}, 64'd1);
    wait_result("divu_stalled", 5);

    // Done cycle: hilo_rd sees new values, and a new start is accepted
    hilo_rd = 1'b1;
    #1 check("stall_done_cycle", {63'd0, stall}, 64'd0);
    launch(2'd3, 32'd12345, -32'sd678, 1'b1);
    hilo_rd = 1'b0;
    wait_result("back_to_back", 0);

    // Reset mid-operation
    launch(2'd3, 32'd77, 32'd88, 1'b0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort_reset", {30'd0, busy, done, hi}, 64'd0);
    check("abort_lo", {32'd0, lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen_done = 1'b0;
      repeat (40) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) seen_done = 1'b1;
      end
      check("abort_no_done", {63'd0, seen_done}, 64'd0);
    end
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
